// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: verdict status, failure cause and trace entry.
package dmem_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PASS    = 2'b01,
        FAIL    = 2'b10,
        TIMEOUT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BADSIG   = 2'd1,
        RANGE    = 2'd2,
        MISALIGN = 2'd3
    } fail_cause_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/store_trace_fifo.sv
// Show-ahead synchronous FIFO of accepted stores; a push while full is dropped unless a pop
// frees the slot in the same cycle, and a dropped push sets a sticky overflow flag.
module store_trace_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  trace_entry_t push_data_i,
    input  logic         pop_i,
    output trace_entry_t head_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         overflow_o
);

    localparam int PW = $clog2(DEPTH);

    trace_entry_t mem_q [DEPTH];
    logic [PW:0]  wptr_q, wptr_d;
    logic [PW:0]  rptr_q, rptr_d;
    logic         ovf_q, ovf_d;
    logic         empty, full, do_pop, do_push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_i && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wptr_q[PW-1:0]] <= push_data_i;
        end
    end

    assign head_o     = mem_q[rptr_q[PW-1:0]];
    assign valid_o    = !empty;
    assign full_o     = full;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the core's load/store port with a sticky pass/fail/timeout verdict.
// Optional store trace FIFO enabled by defining DMEM_STORE_TRACE_EN.
//   state   | meaning
//   RUN     | no verdict yet, timeout counter running
//   PASS    | signature word written with the pass value
//   FAIL    | bad signature, out-of-range or misaligned store (see fail_cause)
//   TIMEOUT | TIMEOUT_CYCLES elapsed in RUN without a verdict
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int SIG_ADDR       = 100,
    parameter int PASS_VALUE     = 25,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TRACE_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output status_t     status,
    output fail_cause_t fail_cause,
    output logic [15:0] store_count,
    output logic        trace_valid,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    input  logic        trace_pop,
    output logic        trace_overflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SIG_W    = 32'(SIG_ADDR);
    localparam logic [31:0] PASS_W   = 32'(PASS_VALUE);

    logic [31:0] mem_q [DEPTH];
    logic        in_range, aligned;
    logic        st_misaligned, st_out_of_range, st_accepted;

    status_t     state_q, state_d;
    fail_cause_t cause_q, cause_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] count_q, count_d;

    assign in_range        = (DataAdr[31:AW+2] == '0);
    assign aligned         = is_word_aligned(DataAdr[1:0]);
    assign st_misaligned   = MemWrite && !aligned;
    assign st_out_of_range = MemWrite && aligned && !in_range;
    assign st_accepted     = MemWrite && aligned && in_range;

    // Combinational read returns the pre-write word when the same address is stored this cycle.
    assign ReadData = in_range ? mem_q[DataAdr[AW+1:2]] : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset && st_accepted) begin
            mem_q[DataAdr[AW+1:2]] <= WriteData;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tmo_d   = tmo_q;
        if (state_q == RUN) begin
            if (st_misaligned) begin
                state_d = FAIL;
                cause_d = MISALIGN;
            end else if (st_out_of_range) begin
                state_d = FAIL;
                cause_d = RANGE;
            end else if (st_accepted && DataAdr == SIG_W) begin
                if (WriteData == PASS_W) begin
                    state_d = PASS;
                end else begin
                    state_d = FAIL;
                    cause_d = BADSIG;
                end
            end else if (tmo_q == TMO_LAST) begin
                state_d = TIMEOUT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (st_accepted && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cause_q <= NONE;
            tmo_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
        end
    end

    assign status      = state_q;
    assign fail_cause  = cause_q;
    assign store_count = count_q;

`ifdef DMEM_STORE_TRACE_EN
    trace_entry_t push_entry, head_entry;
    logic         unused_fifo_full;

    assign push_entry = '{addr: DataAdr, data: WriteData};

    store_trace_fifo #(
        .DEPTH(TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .reset      (reset),
        .push_i     (st_accepted),
        .push_data_i(push_entry),
        .pop_i      (trace_pop),
        .head_o     (head_entry),
        .valid_o    (trace_valid),
        .full_o     (unused_fifo_full),
        .overflow_o (trace_overflow)
    );

    assign trace_addr = head_entry.addr;
    assign trace_data = head_entry.data;
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic          unused_trace_pop;

    assign unused_trace_pop = trace_pop;
    assign trace_valid      = 1'b0;
    assign trace_overflow   = 1'b0;
    assign trace_addr       = 32'h0;
    assign trace_data       = 32'h0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the processor's store/load data port: receives DataAdr, WriteData and MemWrite from the core, and returns ReadData.
- Holds word-addressed RAM. Contains a sticky signature/status FSM that decides pass/fail/timeout from the store stream, so benches and FPGA top levels read a verdict instead of snooping the bus.
- Sits beside the processor, opposite the core's memory-write port.

Parameters:
- DEPTH, 64, RAM size in 32-bit words; must be a power of 2, ≥4.
- SIG_ADDR, 100, byte address of the signature word.
- PASS_VALUE, 25, value at SIG_ADDR meaning pass.
- TIMEOUT_CYCLES, 1000, cycles after reset release with no verdict before TIMEOUT.
- TRACE_DEPTH, 4, store-trace FIFO entries; power of 2; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  32  byte address from the core.
- WriteData  in  32  store data.
- ReadData  out  32  load data.
- status  out  2  dmem_pkg status_t: RUN / PASS / FAIL / TIMEOUT.
- fail_cause  out  2  0 none, 1 bad signature value, 2 out of range, 3 misaligned.
- store_count  out  16  accepted stores since reset; saturates at 16'hFFFF.
- trace_valid  out  1  trace FIFO non-empty.
- trace_addr  out  32  head entry address.
- trace_data  out  32  head entry data.
- trace_pop  in  1  dequeue head when trace_valid.
- trace_overflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - status=RUN, fail_cause=0, store_count=0, timeout counter=0.
  - trace FIFO empty, trace_valid=0, trace_overflow=0.
  - RAM contents are not reset.
- Read path:
  - Combinational (single-cycle core): ReadData = RAM[DataAdr[log2(DEPTH)+1:2]] when DataAdr < DEPTH*4, else 32'h0.
  - DataAdr[1:0] is ignored on reads.
  - A read of an address being written in the same cycle returns the old word.
- Write classification, only when MemWrite=1, in priority order:
  - DataAdr[1:0]!=0 → misaligned.
  - DataAdr ≥ DEPTH*4 → out of range.
  - Otherwise → accepted.
- Accepted store:
  - RAM word written at posedge.
  - store_count increments (saturating).
  - Trace push (see optional feature).
- Misaligned and out-of-range stores never modify RAM and never count.
- Status FSM:
  - States RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are absorbing until reset.
  - RUN → PASS: accepted store with DataAdr==SIG_ADDR and WriteData==PASS_VALUE.
  - RUN → FAIL, cause 1: accepted store to SIG_ADDR with any other value.
  - RUN → FAIL, cause 3: misaligned store.
  - RUN → FAIL, cause 2: out-of-range store.
  - RUN → TIMEOUT: counter reaches TIMEOUT_CYCLES-1 while in RUN with no verdict that cycle. A store verdict in the same cycle wins over timeout.
  - status/fail_cause update on the posedge that samples the triggering store (1-cycle latency), and are visible at the following negedge.
- After leaving RUN:
  - Accepted stores still write RAM and still count.
  - Status and cause are frozen.
  - The timeout counter stops.
- Reset mid-operation: all state returns to reset values on the next posedge; an in-flight store in the reset cycle is discarded (no RAM write).

Optional Feature:
- Macro: DMEM_STORE_TRACE_EN.
- Defined:
  - Every accepted store pushes {DataAdr, WriteData} into a TRACE_DEPTH FIFO.
  - Head is presented show-ahead on trace_addr/trace_data; trace_pop with trace_valid dequeues.
  - Push and pop in the same cycle are both honoured, including when full: pop frees a slot, so the push succeeds.
  - Push while full without pop: entry dropped, trace_overflow set (sticky until reset).
  - trace_pop while empty: ignored.
- Undefined: trace_valid, trace_overflow, trace_addr and trace_data are tied to 0; trace_pop is ignored; no FIFO storage is synthesized.

Decomposition:
- Package dmem_pkg:
  - status_t enum: RUN=2'b00, PASS=2'b01, FAIL=2'b10, TIMEOUT=2'b11.
  - fail_cause_t enum: NONE=0, BADSIG=1, RANGE=2, MISALIGN=3.
  - Trace entry struct: addr[31:0], data[31:0].
- Sub-module store_trace_fifo: parameterized synchronous FIFO with push/pop, full/empty and overflow flag. Instantiated only under DMEM_STORE_TRACE_EN.

Test Plan:
- Reset 2 cycles; store 7 @96, store 25 @100 → status=PASS after the @100 posedge, fail_cause=0, store_count=2, ReadData@96=7.
- Store 24 @100 → status=FAIL, fail_cause=1; a later store 25 @100 leaves FAIL, RAM@100=25, store_count=2.
- Store @102 → FAIL, cause 3, RAM unchanged. After reset, store @256 with DEPTH=64 → FAIL, cause 2, store_count=0, ReadData@256=0.
- TIMEOUT_CYCLES=10 with no stores → status=TIMEOUT at cycle 10 after reset release. Same setup with store 25 @100 in the timeout cycle → PASS.
- DMEM_STORE_TRACE_EN: 5 accepted stores @0,4,8,12,16 with no pop → trace_overflow=1; pops return addrs 0,4,8,12; trace_valid=0 after the 4th pop. Push+pop while full → no overflow.
- Assert reset mid-sequence, with a store in the reset cycle → RAM not written, status=RUN, store_count=0, trace empty.
